soc_frame_serializer: RTL and testbench

Upstream stage of the battery-management core. Accepts one parallel measurement set per frame: a 13-bit pack current and four 10-bit cell SoC values. It converts the set into the serial frame the core consumes: a one-cycle `start` pulse, then the current on `i` and the four SoC values on `socin1..socin4`, all LSB first and bit-aligned. It also clamps out-of-range SoC values and refuses a new frame until the core reports it is free.

---
 rtl/soc_frame_serializer.sv | 174 +++++++++++++++++
 tb/tb_soc_frame_serializer.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/soc_frame_serializer.sv
// soc_frame_serializer
// Takes one parallel measurement set (pack current + four cell SoC codes),
// clamps the SoC codes, and sends them to the battery-management core as a
// bit-aligned LSB-first serial frame preceded by a one-cycle start pulse.
//
// state | meaning
// IDLE  | waiting for a handshake; req_ready follows core_ready
// START | one-cycle start pulse to the core
// LEAD  | LEAD_CYCLES quiet cycles before the first data bit
// SHIFT | 13 data cycles; SoC lanes carry 10 bits then 3 zero bits
module soc_frame_serializer #(
  parameter int LEAD_CYCLES = 2,
  parameter int SOC_MAX     = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [12:0] current_in,
  input  logic [9:0]  soc1_in,
  input  logic [9:0]  soc2_in,
  input  logic [9:0]  soc3_in,
  input  logic [9:0]  soc4_in,
  input  logic        core_ready,
  output logic        start,
  output logic        i,
  output logic        socin1,
  output logic        socin2,
  output logic        socin3,
  output logic        socin4,
  output logic        busy,
  output logic [3:0]  sat_flags,
  output logic [7:0]  frame_count
);

  localparam logic [2:0] LEAD_INIT = 3'(LEAD_CYCLES - 1);
  localparam logic [9:0] SOC_LIMIT = 10'(SOC_MAX);
  localparam logic [3:0] LAST_BIT  = 4'd12;
  localparam logic [3:0] LAST_SOC  = 4'd9;

  typedef enum logic [1:0] {IDLE, START, LEAD, SHIFT} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [2:0]       lead_cnt;
  logic [3:0]       bit_cnt;
  logic [12:0]      cur_sh;
  logic [3:0][9:0]  soc_sh;
  logic [3:0][9:0]  soc_in_v;
  logic [3:0][9:0]  soc_clamped;
  logic [3:0]       clamp_hit;
  logic [3:0]       soc_q;
  logic             accept;
  logic             lead_done;
  logic             last_bit;
  logic             load_bit;
  logic             soc_bit_en;

  assign soc_in_v = {soc4_in, soc3_in, soc2_in, soc1_in};

  assign accept     = (state == IDLE) && req_valid && core_ready;
  assign lead_done  = (state == LEAD) && (lead_cnt == 3'd0);
  assign last_bit   = (state == SHIFT) && (bit_cnt == LAST_BIT);
  assign load_bit   = lead_done || ((state == SHIFT) && !last_bit);
  // SoC lanes carry data only for bit indices 0..9 of the frame.
  assign soc_bit_en = lead_done || (bit_cnt < LAST_SOC);

  assign socin1 = soc_q[0];
  assign socin2 = soc_q[1];
  assign socin3 = soc_q[2];
  assign socin4 = soc_q[3];

  // Unsigned clamp of each SoC code to the legal maximum.
  always_comb begin
    clamp_hit   = '0;
    soc_clamped = '0;
    for (int k = 0; k < 4; k++) begin
      clamp_hit[k]   = soc_in_v[k] > SOC_LIMIT;
      soc_clamped[k] = clamp_hit[k] ? SOC_LIMIT : soc_in_v[k];
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and handshake/status outputs.
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    busy      = 1'b0;
    req_ready = 1'b0;
    case (state)
      IDLE: begin
        req_ready = core_ready;
        if (req_valid && core_ready) state_nxt = START;
      end
      START: begin
        start     = 1'b1;
        busy      = 1'b1;
        state_nxt = LEAD;
      end
      LEAD: begin
        busy = 1'b1;
        if (lead_cnt == 3'd0) state_nxt = SHIFT;
      end
      SHIFT: begin
        busy = 1'b1;
        if (bit_cnt == LAST_BIT) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Lead-in down-counter and bit index counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lead_cnt <= 3'd0;
      bit_cnt  <= 4'd0;
    end else begin
      if (state == START)
        lead_cnt <= LEAD_INIT;
      else if ((state == LEAD) && (lead_cnt != 3'd0))
        lead_cnt <= lead_cnt - 3'd1;

      if (lead_done)
        bit_cnt <= 4'd0;
      else if ((state == SHIFT) && !last_bit)
        bit_cnt <= bit_cnt + 4'd1;
    end
  end

  // Shadow registers: captured on acceptance, shifted right as bits go out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_sh <= '0;
      soc_sh <= '0;
    end else if (accept) begin
      cur_sh <= current_in;
      soc_sh <= soc_clamped;
    end else if (load_bit) begin
      cur_sh <= cur_sh >> 1;
      for (int k = 0; k < 4; k++) soc_sh[k] <= soc_sh[k] >> 1;
    end
  end

  // Registered serial lanes, loaded so bit n lines up with SHIFT step n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i     <= 1'b0;
      soc_q <= '0;
    end else if (load_bit) begin
      i <= cur_sh[0];
      for (int k = 0; k < 4; k++) soc_q[k] <= soc_sh[k][0] & soc_bit_en;
    end else begin
      i     <= 1'b0;
      soc_q <= '0;
    end
  end

  // Clamp flags of the accepted set and completed-frame counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_flags   <= '0;
      frame_count <= '0;
    end else begin
      if (accept)   sat_flags   <= clamp_hit;
      if (last_bit) frame_count <= frame_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_soc_frame_serializer.sv
// Directed bench for soc_frame_serializer: default-lead instance for frame
// content, clamping, back-pressure and reset; a LEAD_CYCLES=1 instance for
// back-to-back period and frame counter wrap.
module tb_soc_frame_serializer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        core_ready;
  logic [12:0] current_in;
  logic [9:0]  soc1_in, soc2_in, soc3_in, soc4_in;

  logic        req_ready, start, i, socin1, socin2, socin3, socin4, busy;
  logic [3:0]  sat_flags;
  logic [7:0]  frame_count;

  logic        req_ready_b, start_b, i_b, socin1_b, socin2_b, socin3_b, socin4_b, busy_b;
  logic [3:0]  sat_flags_b;
  logic [7:0]  frame_count_b;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  soc_frame_serializer dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .current_in(current_in), .soc1_in(soc1_in), .soc2_in(soc2_in),
    .soc3_in(soc3_in), .soc4_in(soc4_in), .core_ready(core_ready),
    .start(start), .i(i), .socin1(socin1), .socin2(socin2), .socin3(socin3),
    .socin4(socin4), .busy(busy), .sat_flags(sat_flags), .frame_count(frame_count)
  );

  soc_frame_serializer #(.LEAD_CYCLES(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready_b),
    .current_in(current_in), .soc1_in(soc1_in), .soc2_in(soc2_in),
    .soc3_in(soc3_in), .soc4_in(soc4_in), .core_ready(core_ready),
    .start(start_b), .i(i_b), .socin1(socin1_b), .socin2(socin2_b), .socin3(socin3_b),
    .socin4(socin4_b), .busy(busy_b), .sat_flags(sat_flags_b), .frame_count(frame_count_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_inputs(input logic [12:0] cur, input logic [9:0] a, b, c, d);
    current_in = cur;
    soc1_in = a; soc2_in = b; soc3_in = c; soc4_in = d;
  endtask

  // Offers a set, waits for start, then records the 13 data cycles of the
  // default-lead instance (bit n sampled 3+n cycles after start).
  task automatic run_frame(output logic [12:0] cap_i, cap1, cap2, cap3, cap4,
                           output int extra_starts, output int lead_nonzero,
                           output logic busy_last, output logic busy_end,
                           output logic [7:0] fc_end, output bit timeout);
    int n;
    timeout = 1'b1;
    cap_i = '0; cap1 = '0; cap2 = '0; cap3 = '0; cap4 = '0;
    extra_starts = 0; lead_nonzero = 0;
    busy_last = 1'b0; busy_end = 1'b1; fc_end = '0;
    req_valid = 1'b1;
    for (int w = 0; w < 50; w++) begin
      tick();
      if (start === 1'b1) begin
        timeout = 1'b0;
        break;
      end
    end
    req_valid = 1'b0;
    if (!timeout) begin
      for (int off = 1; off <= 16; off++) begin
        tick();
        if (start !== 1'b0) extra_starts++;
        if (off <= 2) begin
          if ({i, socin1, socin2, socin3, socin4} !== 5'b0) lead_nonzero++;
        end else if (off <= 15) begin
          n = off - 3;
          cap_i[n] = i; cap1[n] = socin1; cap2[n] = socin2;
          cap3[n] = socin3; cap4[n] = socin4;
        end
        if (off == 15) busy_last = busy;
        if (off == 16) begin
          busy_end = busy;
          fc_end   = frame_count;
        end
      end
    end
  endtask

  task automatic test_reset();
    int bad;
    rst_n = 1'b0; req_valid = 1'b0; core_ready = 1'b0;
    set_inputs(13'h0, 10'd0, 10'd0, 10'd0, 10'd0);
    #1;
    checks++;
    if ({start, i, socin1, socin2, socin3, socin4, busy, req_ready} !== 8'b0) begin
      failures++;
      $display("FAIL reset_outputs got=%b expected=00000000",
               {start, i, socin1, socin2, socin3, socin4, busy, req_ready});
    end
    checks++;
    if ({sat_flags, frame_count} !== 12'h000) begin
      failures++;
      $display("FAIL reset_status got flags=%b count=%0d expected 0/0", sat_flags, frame_count);
    end
    repeat (2) @(posedge clk);
    #4 rst_n = 1'b1;
    core_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("FAIL idle_req_ready got=%b expected=1", req_ready);
    end
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if ({start, i, socin1, socin2, socin3, socin4, busy} !== 7'b0 || frame_count !== 8'd0)
        bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL idle_run got %0d non-quiet cycles expected 0", bad);
    end
  endtask

  task automatic test_single_frame();
    logic [12:0] ci, c1, c2, c3, c4;
    int xs, ln; logic bl, be; logic [7:0] fc; bit to;
    set_inputs(13'h0ABC, 10'd500, 10'd250, 10'd125, 10'd1000);
    run_frame(ci, c1, c2, c3, c4, xs, ln, bl, be, fc, to);
    checks++;
    if (to) begin
      failures++;
      $display("FAIL single_start_timeout no start within 50 cycles");
    end
    checks++;
    if (xs != 0 || ln != 0) begin
      failures++;
      $display("FAIL single_quiet extra_starts=%0d lead_nonzero=%0d expected 0/0", xs, ln);
    end
    checks++;
    if (ci !== 13'h0ABC) begin
      failures++;
      $display("FAIL single_i got=%h expected=0abc", ci);
    end
    checks++;
    if (c1 !== 13'd500 || c2 !== 13'd250 || c3 !== 13'd125 || c4 !== 13'd1000) begin
      failures++;
      $display("FAIL single_soc got=%0d,%0d,%0d,%0d expected=500,250,125,1000", c1, c2, c3, c4);
    end
    checks++;
    if (bl !== 1'b1 || be !== 1'b0) begin
      failures++;
      $display("FAIL single_busy got last=%b end=%b expected 1/0", bl, be);
    end
    checks++;
    if (fc !== 8'd1 || sat_flags !== 4'b0000) begin
      failures++;
      $display("FAIL single_status got count=%0d flags=%b expected 1/0000", fc, sat_flags);
    end
  endtask

  task automatic test_clamp();
    logic [12:0] ci, c1, c2, c3, c4;
    int xs, ln; logic bl, be; logic [7:0] fc; bit to;
    set_inputs(13'h1234, 10'd1000, 10'd1023, 10'd0, 10'd1001);
    run_frame(ci, c1, c2, c3, c4, xs, ln, bl, be, fc, to);
    checks++;
    if (to) begin
      failures++;
      $display("FAIL clamp_start_timeout no start within 50 cycles");
    end
    checks++;
    if (ci !== 13'h1234) begin
      failures++;
      $display("FAIL clamp_i got=%h expected=1234", ci);
    end
    checks++;
    if (c1 !== 13'd1000 || c2 !== 13'd1000 || c3 !== 13'd0 || c4 !== 13'd1000) begin
      failures++;
      $display("FAIL clamp_soc got=%0d,%0d,%0d,%0d expected=1000,1000,0,1000", c1, c2, c3, c4);
    end
    checks++;
    if (sat_flags !== 4'b1010) begin
      failures++;
      $display("FAIL clamp_flags got=%b expected=1010", sat_flags);
    end
    checks++;
    if (fc !== 8'd2) begin
      failures++;
      $display("FAIL clamp_count got=%0d expected=2", fc);
    end
  endtask

  task automatic test_back_pressure();
    int bad;
    set_inputs(13'h0055, 10'd1, 10'd2, 10'd3, 10'd4);
    core_ready = 1'b0;
    req_valid  = 1'b1;
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (start !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL bp_hold got %0d cycles with start/busy/ready expected 0", bad);
    end
    core_ready = 1'b1;
    tick();
    checks++;
    if (start !== 1'b1) begin
      failures++;
      $display("FAIL bp_accept start got=%b expected=1", start);
    end
    req_valid  = 1'b0;
    core_ready = 1'b0;
    tick();
    checks++;
    if (req_ready !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL bp_midframe got ready=%b busy=%b expected 0/1", req_ready, busy);
    end
    repeat (15) tick();
    checks++;
    if (frame_count !== 8'd3 || busy !== 1'b0 || sat_flags !== 4'b0000) begin
      failures++;
      $display("FAIL bp_complete got count=%0d busy=%b flags=%b expected 3/0/0000",
               frame_count, busy, sat_flags);
    end
    core_ready = 1'b1;
  endtask

  task automatic test_reset_mid_frame();
    logic [12:0] ci, c1, c2, c3, c4;
    int xs, ln; logic bl, be; logic [7:0] fc; bit to;
    bit got;
    set_inputs(13'h1FFF, 10'd1023, 10'd1023, 10'd1023, 10'd1023);
    req_valid = 1'b1;
    got = 1'b0;
    for (int w = 0; w < 50; w++) begin
      tick();
      if (start === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    req_valid = 1'b0;
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL rst_mid_start_timeout no start within 50 cycles");
    end
    repeat (9) tick();
    checks++;
    if (i !== 1'b1 || socin1 !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid_bit6 got i=%b soc1=%b busy=%b expected 1/1/1", i, socin1, busy);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({start, i, socin1, socin2, socin3, socin4, busy} !== 7'b0) begin
      failures++;
      $display("FAIL rst_mid_outputs got=%b expected=0000000",
               {start, i, socin1, socin2, socin3, socin4, busy});
    end
    checks++;
    if (frame_count !== 8'd0 || sat_flags !== 4'b0000 || req_ready !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid_status got count=%0d flags=%b ready=%b expected 0/0000/1",
               frame_count, sat_flags, req_ready);
    end
    #1 rst_n = 1'b1;
    set_inputs(13'h0ABC, 10'd500, 10'd250, 10'd125, 10'd1000);
    run_frame(ci, c1, c2, c3, c4, xs, ln, bl, be, fc, to);
    checks++;
    if (to || ci !== 13'h0ABC || c1 !== 13'd500 || c4 !== 13'd1000) begin
      failures++;
      $display("FAIL rst_next_frame got timeout=%0d i=%h soc1=%0d soc4=%0d expected 0/0abc/500/1000",
               to, ci, c1, c4);
    end
    checks++;
    if (fc !== 8'd1) begin
      failures++;
      $display("FAIL rst_next_count got=%0d expected=1", fc);
    end
  endtask

  task automatic test_back_to_back_wrap();
    int nst, last, cyc;
    bit done;
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    set_inputs(13'h0F0F, 10'd10, 10'd20, 10'd30, 10'd40);
    core_ready = 1'b1;
    req_valid  = 1'b1;
    nst = 0; last = 0; done = 1'b0;
    for (cyc = 0; cyc < 5000; cyc++) begin
      tick();
      if (start_b === 1'b1) begin
        nst++;
        if (nst > 1) begin
          checks++;
          if (cyc - last != 16) begin
            failures++;
            $display("FAIL b2b_period frame=%0d got=%0d expected=16", nst, cyc - last);
          end
        end
        last = cyc;
      end else if (cyc == last + 15 && nst == 255) begin
        checks++;
        if (frame_count_b !== 8'd255) begin
          failures++;
          $display("FAIL b2b_count255 got=%0d expected=255", frame_count_b);
        end
      end else if (cyc == last + 15 && nst == 256) begin
        checks++;
        if (frame_count_b !== 8'd0 || busy_b !== 1'b0) begin
          failures++;
          $display("FAIL b2b_wrap got count=%0d busy=%b expected 0/0", frame_count_b, busy_b);
        end
        done = 1'b1;
        break;
      end
    end
    req_valid = 1'b0;
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL b2b_timeout got %0d starts expected 256", nst);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_clamp();
    test_back_pressure();
    test_reset_mid_frame();
    test_back_to_back_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
